// File: rtl/cr_structs_pkg.sv
// Shared TLV stream types: word bus, TLV type codes and routing codes used by the
// TLV parser blocks.
package cr_structs;

  typedef enum logic [7:0] {
    RQE   = 8'd0,
    CMD   = 8'd1,
    KEY   = 8'd2,
    DATA  = 8'd3,
    CQE   = 8'd4,
    PHD   = 8'd5,
    PFD   = 8'd6,
    FTR   = 8'd7
  } tlv_types_e;

  // Two-bit destination code held per TLV type in the route map
  typedef enum logic [1:0] {
    RT_PT   = 2'b00,
    RT_USR  = 2'b01,
    RT_BOTH = 2'b10,
    RT_DISC = 2'b11
  } tlv_route_e;

  typedef struct packed {
    tlv_types_e  typen;
    logic        sot;
    logic        eot;
    logic        tlast;
    logic        tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
    logic        insert;
    logic [15:0] ordern;
  } tlvp_if_bus_t;

endpackage

// File: rtl/cr_tlvp_rt.sv
// TLV router: steers each TLV to the pass-through and/or user FIFO according to a
// per-type route map latched at start-of-TLV, and counts complete TLVs delivered.
module cr_tlvp_rt
  import cr_structs::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tlvp_id_out_valid,
  input  tlvp_if_bus_t         tlvp_id_out,
  input  logic [63:0]          tlvp_route_map,
  input  logic                 pt_ib_full,
  input  logic                 usr_ib_full,
  output logic                 pt_ib_wr,
  output logic                 usr_ib_wr,
  output tlvp_if_bus_t         pt_ib_wdata,
  output tlvp_if_bus_t         usr_ib_wdata,
  output logic [CNT_WIDTH-1:0] pt_tlv_cnt,
  output logic [CNT_WIDTH-1:0] usr_tlv_cnt,
  output logic                 tlvp_route_error
);

  typedef enum logic [2:0] {IDLE, PT, USR, BOTH, DISC, DROP} state_e;

  state_e     state;
  state_e     cur_route;
  state_e     next_state;
  tlv_route_e map_code;
  logic       pt_go;
  logic       usr_go;
  logic       err_c;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic state_e route_state(input tlv_route_e code);
    case (code)
      RT_PT:   return PT;
      RT_USR:  return USR;
      RT_BOTH: return BOTH;
      default: return DISC;
    endcase
  endfunction

  // A start word always re-decodes the map; other words follow the route latched at sot.
  always_comb begin
    map_code   = tlv_route_e'(tlvp_route_map[{tlvp_id_out.typen[4:0], 1'b0} +: 2]);
    cur_route  = state;
    next_state = state;
    err_c      = 1'b0;
    pt_go      = 1'b0;
    usr_go     = 1'b0;
    if (tlvp_id_out_valid) begin
      if (tlvp_id_out.sot) begin
        err_c     = (state inside {PT, USR, BOTH, DISC});
        cur_route = route_state(map_code);
      end else if (state == IDLE) begin
        err_c     = 1'b1;
        cur_route = DROP;
      end
      if (cur_route inside {PT, BOTH}) begin
        pt_go = ~pt_ib_full;
        if (pt_ib_full) err_c = 1'b1;
      end
      if (cur_route inside {USR, BOTH}) begin
        usr_go = ~usr_ib_full;
        if (usr_ib_full) err_c = 1'b1;
      end
      next_state = tlvp_id_out.eot ? IDLE : cur_route;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pt_ib_wr         <= 1'b0;
      usr_ib_wr        <= 1'b0;
      pt_ib_wdata      <= '0;
      usr_ib_wdata     <= '0;
      pt_tlv_cnt       <= '0;
      usr_tlv_cnt      <= '0;
      tlvp_route_error <= 1'b0;
    end else begin
      state            <= next_state;
      pt_ib_wr         <= pt_go;
      usr_ib_wr        <= usr_go;
      tlvp_route_error <= err_c;
      if (pt_go) begin
        pt_ib_wdata <= tlvp_id_out;
        if (tlvp_id_out.eot) pt_tlv_cnt <= sat_inc(pt_tlv_cnt);
      end
      if (usr_go) begin
        usr_ib_wdata <= tlvp_id_out;
        if (tlvp_id_out.eot) usr_tlv_cnt <= sat_inc(usr_tlv_cnt);
      end
    end
  end

endmodule

// File: tb/tb_cr_tlvp_rt.sv
// Self-checking bench for cr_tlvp_rt: directed scenarios plus random traffic,
// compared each cycle against a TLV-level reference model.
module tb_cr_tlvp_rt;
  import cr_structs::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tlvp_id_out_valid;
  tlvp_if_bus_t tlvp_id_out;
  logic [63:0]  tlvp_route_map;
  logic         pt_ib_full;
  logic         usr_ib_full;
  logic         pt_ib_wr;
  logic         usr_ib_wr;
  tlvp_if_bus_t pt_ib_wdata;
  tlvp_if_bus_t usr_ib_wdata;
  logic [15:0]  pt_tlv_cnt;
  logic [15:0]  usr_tlv_cnt;
  logic         tlvp_route_error;

  cr_tlvp_rt #(.CNT_WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tlvp_id_out_valid(tlvp_id_out_valid),
    .tlvp_id_out      (tlvp_id_out),
    .tlvp_route_map   (tlvp_route_map),
    .pt_ib_full       (pt_ib_full),
    .usr_ib_full      (usr_ib_full),
    .pt_ib_wr         (pt_ib_wr),
    .usr_ib_wr        (usr_ib_wr),
    .pt_ib_wdata      (pt_ib_wdata),
    .usr_ib_wdata     (usr_ib_wdata),
    .pt_tlv_cnt       (pt_tlv_cnt),
    .usr_tlv_cnt      (usr_tlv_cnt),
    .tlvp_route_error (tlvp_route_error)
  );

  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model: whether we are inside a routed TLV, discarding an orphan, and
  // which destination code was captured when the TLV started.
  bit           m_in_tlv;
  bit           m_dropping;
  logic [1:0]   m_code;
  logic         exp_pt_wr, exp_usr_wr, exp_err;
  tlvp_if_bus_t exp_pt_data, exp_usr_data;
  int           exp_pt_cnt, exp_usr_cnt;
  int           pt_seen, usr_seen, err_seen;

  task automatic modelReset();
    m_in_tlv = 0; m_dropping = 0; m_code = 2'b00;
    exp_pt_wr = 0; exp_usr_wr = 0; exp_err = 0;
    exp_pt_data = '0; exp_usr_data = '0;
    exp_pt_cnt = 0; exp_usr_cnt = 0;
  endtask

  task automatic modelStep(input logic v, input tlvp_if_bus_t w, input logic pf, input logic uf);
    exp_pt_wr = 0; exp_usr_wr = 0; exp_err = 0;
    if (v) begin
      if (w.sot) begin
        if (m_in_tlv) exp_err = 1;
        m_code = tlvp_route_map[2*int'(w.typen[4:0]) +: 2];
        m_in_tlv = 1; m_dropping = 0;
      end else if (!m_in_tlv && !m_dropping) begin
        exp_err = 1; m_dropping = 1;
      end
      if (m_in_tlv) begin
        if (m_code == 2'd0 || m_code == 2'd2) begin
          if (pf) exp_err = 1;
          else begin
            exp_pt_wr = 1; exp_pt_data = w;
            if (w.eot && exp_pt_cnt < 65535) exp_pt_cnt++;
          end
        end
        if (m_code == 2'd1 || m_code == 2'd2) begin
          if (uf) exp_err = 1;
          else begin
            exp_usr_wr = 1; exp_usr_data = w;
            if (w.eot && exp_usr_cnt < 65535) exp_usr_cnt++;
          end
        end
      end
      if (w.eot) begin m_in_tlv = 0; m_dropping = 0; end
    end
  endtask

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    assert_count++;
    assert (obs === expv) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".pt_wr"},    pt_ib_wr,         exp_pt_wr);
    checkVal({tag, ".usr_wr"},   usr_ib_wr,        exp_usr_wr);
    checkVal({tag, ".pt_data"},  pt_ib_wdata,      exp_pt_data);
    checkVal({tag, ".usr_data"}, usr_ib_wdata,     exp_usr_data);
    checkVal({tag, ".err"},      tlvp_route_error, exp_err);
    checkVal({tag, ".pt_cnt"},   pt_tlv_cnt,       exp_pt_cnt[15:0]);
    checkVal({tag, ".usr_cnt"},  usr_tlv_cnt,      exp_usr_cnt[15:0]);
  endtask

  task automatic applyStimulus(input string tag, input logic v, input tlvp_if_bus_t w,
                               input logic pf, input logic uf, input bit chk);
    tlvp_id_out_valid = v;
    tlvp_id_out       = w;
    pt_ib_full        = pf;
    usr_ib_full       = uf;
    modelStep(v, w, pf, uf);
    @(posedge clk);
    #1;
    pt_seen  += int'(pt_ib_wr);
    usr_seen += int'(usr_ib_wr);
    err_seen += int'(tlvp_route_error);
    if (chk) checkOutput(tag);
  endtask

  function automatic tlvp_if_bus_t mkWord(input tlv_types_e t, input logic s, input logic e);
    tlvp_if_bus_t w;
    w        = '0;
    w.typen  = t;
    w.sot    = s;
    w.eot    = e;
    w.tlast  = e;
    w.tid    = 1'($urandom);
    w.tstrb  = 8'($urandom);
    w.tuser  = 8'($urandom);
    w.tdata  = {$urandom, $urandom};
    w.insert = 1'($urandom);
    w.ordern = 16'($urandom);
    return w;
  endfunction

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, tlvp_id_out, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic clearSeen();
    pt_seen = 0; usr_seen = 0; err_seen = 0;
  endtask

  initial begin
    tlvp_if_bus_t w;
    logic v, s, e, pf, uf;
    pt_seen = 0; usr_seen = 0; err_seen = 0;
    rst_n = 1'b0;
    tlvp_id_out_valid = 1'b0;
    tlvp_id_out = '0;
    tlvp_route_map = '0;
    pt_ib_full = 1'b0;
    usr_ib_full = 1'b0;
    modelReset();
    #2;
    checkOutput("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle("post_reset");

    $display("[TB] three-word CMD TLV to pass-through");
    clearSeen();
    tlvp_route_map = 64'h0;
    applyStimulus("cmd_w1", 1'b1, mkWord(CMD, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("cmd_w2", 1'b1, mkWord(CMD, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("cmd_w3", 1'b1, mkWord(CMD, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    idle("cmd_idle");
    checkVal("cmd_pt_writes", pt_seen, 3);
    checkVal("cmd_usr_writes", usr_seen, 0);

    $display("[TB] DATA TLV to both with user full on word 2");
    clearSeen();
    tlvp_route_map = 64'h80;
    applyStimulus("data_w1", 1'b1, mkWord(DATA, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("data_w2", 1'b1, mkWord(DATA, 1'b0, 1'b0), 1'b0, 1'b1, 1'b1);
    applyStimulus("data_w3", 1'b1, mkWord(DATA, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("data_w4", 1'b1, mkWord(DATA, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    idle("data_idle");
    checkVal("data_pt_writes", pt_seen, 4);
    checkVal("data_usr_writes", usr_seen, 3);
    checkVal("data_err_pulses", err_seen, 1);
    checkVal("data_usr_cnt", usr_tlv_cnt, 1);

    $display("[TB] orphan words without sot");
    clearSeen();
    applyStimulus("orph_w1", 1'b1, mkWord(CMD, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("orph_w2", 1'b1, mkWord(CMD, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("orph_w3", 1'b1, mkWord(CMD, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    idle("orph_idle");
    checkVal("orph_writes", pt_seen + usr_seen, 0);
    checkVal("orph_err_pulses", err_seen, 1);
    applyStimulus("orph_next", 1'b1, mkWord(CMD, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1);
    idle("orph_next_idle");

    $display("[TB] route map change inside a TLV");
    clearSeen();
    tlvp_route_map = 64'h0;
    applyStimulus("map_w1", 1'b1, mkWord(CMD, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1);
    tlvp_route_map = 64'h4;
    applyStimulus("map_w2", 1'b1, mkWord(CMD, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("map_w3", 1'b1, mkWord(CMD, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    checkVal("map_pt_writes", pt_seen, 3);
    applyStimulus("map_n1", 1'b1, mkWord(CMD, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("map_n2", 1'b1, mkWord(CMD, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    idle("map_idle");
    checkVal("map_usr_writes", usr_seen, 2);

    $display("[TB] reset in the middle of a five-word TLV");
    clearSeen();
    tlvp_route_map = 64'h0;
    applyStimulus("rst_w1", 1'b1, mkWord(CMD, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("rst_w2", 1'b1, mkWord(CMD, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
    tlvp_id_out_valid = 1'b0;
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkOutput("rst_during");
    @(posedge clk); #1;
    checkOutput("rst_held");
    rst_n = 1'b1;
    clearSeen();
    applyStimulus("rst_w3", 1'b1, mkWord(CMD, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("rst_w4", 1'b1, mkWord(CMD, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus("rst_w5", 1'b1, mkWord(CMD, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    idle("rst_idle");
    checkVal("rst_writes", pt_seen + usr_seen, 0);
    checkVal("rst_err_pulses", err_seen, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) tlvp_route_map = {$urandom, $urandom};
      v  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 3) == 0);
      e  = ($urandom_range(0, 2) == 0);
      pf = ($urandom_range(0, 4) == 0);
      uf = ($urandom_range(0, 4) == 0);
      w  = mkWord(tlv_types_e'(8'($urandom_range(0, 7))), s, e);
      applyStimulus("rand", v, w, pf, uf, 1'b1);
    end
    idle("rand_idle");

    $display("[TB] pass-through counter saturation");
    tlvp_route_map = 64'h0;
    for (int i = 0; i < 70000 && exp_pt_cnt < 65535; i++)
      applyStimulus("sat_fill", 1'b1, mkWord(CMD, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
    idle("sat_full");
    checkVal("sat_at_max", pt_tlv_cnt, 16'hFFFF);
    applyStimulus("sat_extra", 1'b1, mkWord(CMD, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1);
    idle("sat_after");
    checkVal("sat_hold", pt_tlv_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
